fpmul_arbiter: RTL

FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

---
 rtl/fpmul_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: round-robin arbiter that lets two requesters share one
// serial-operand floating-point multiplier.
//
// A transaction walks IDLE -> SEND_A -> SEND_B -> WAIT -> RESP -> IDLE.
// - Operands are captured when the request is granted.
// - They are sent A then B on mul_a.
// - The product is registered when mul_ready arrives.
// - The winner sees a one-cycle done pulse in RESP.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   req0/a0/b0, done0     requester 0 request, operands, completion pulse
//   req1/a1/b1, done1     requester 1 request, operands, completion pulse
//   result, err           product and timeout flag, held until next RESP
//   busy                  high whenever the FSM is not in IDLE
//   mul_a, mul_valid      serial operand bus to the multiplier
//   mul_product, mul_ready multiplier result and its valid pulse
//
// Optional feature macro: FPMUL_ARB_TIMEOUT_EN.
// - Defined: WAIT is bounded by TIMEOUT_CYCLES. On expiry the transaction
//   completes with a quiet NaN and err=1.
// - Undefined: WAIT waits indefinitely and err is tied low.
module fpmul_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    output logic        done0,
    input  logic        req1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        done1,
    output logic [31:0] result,
    output logic        err,
    output logic        busy,
    output logic [31:0] mul_a,
    output logic        mul_valid,
    input  logic [31:0] mul_product,
    input  logic        mul_ready
);

    localparam int unsigned DATA_W = 32;
    localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_A,
        S_SEND_B,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_winner;
    logic              r_last;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;

    logic              w_pick;
    logic              w_winner_nxt;
    logic              w_last_nxt;
    logic [DATA_W-1:0] w_a_nxt;
    logic [DATA_W-1:0] w_b_nxt;
    logic [DATA_W-1:0] w_mul_a_nxt;
    logic              w_mul_valid_nxt;
    logic              w_done0_nxt;
    logic              w_done1_nxt;
    logic [DATA_W-1:0] w_result_nxt;
    logic              w_busy_nxt;

`ifdef FPMUL_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_err_nxt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign err = 1'b0;
`endif

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
    assign w_pick = (req0 & req1) ? ~r_last : req1;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_winner_nxt    = r_winner;
        w_last_nxt      = r_last;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_mul_a_nxt     = '0;
        w_mul_valid_nxt = 1'b0;
        w_done0_nxt     = 1'b0;
        w_done1_nxt     = 1'b0;
        w_result_nxt    = result;
`ifdef FPMUL_ARB_TIMEOUT_EN
        w_cnt_nxt       = r_cnt;
        w_err_nxt       = err;
`endif
        case (r_state)
            S_IDLE: begin
                if (req0 | req1) begin
                    w_state_nxt     = S_SEND_A;
                    w_winner_nxt    = w_pick;
                    w_a_nxt         = w_pick ? a1 : a0;
                    w_b_nxt         = w_pick ? b1 : b0;
                    // mul_a is registered, so operand A is loaded on entry to SEND_A
                    w_mul_a_nxt     = w_pick ? a1 : a0;
                    w_mul_valid_nxt = 1'b1;
                end
            end
            S_SEND_A: begin
                w_state_nxt     = S_SEND_B;
                w_mul_a_nxt     = r_b;
                w_mul_valid_nxt = 1'b1;
            end
            S_SEND_B: begin
                w_state_nxt = S_WAIT;
`ifdef FPMUL_ARB_TIMEOUT_EN
                w_cnt_nxt   = '0;
`endif
            end
            S_WAIT: begin
                if (mul_ready) begin
                    w_state_nxt  = S_RESP;
                    w_result_nxt = mul_product;
                    w_done0_nxt  = ~r_winner;
                    w_done1_nxt  = r_winner;
`ifdef FPMUL_ARB_TIMEOUT_EN
                    w_err_nxt    = 1'b0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt  = S_RESP;
                    w_result_nxt = QNAN;
                    w_err_nxt    = 1'b1;
                    w_done0_nxt  = ~r_winner;
                    w_done1_nxt  = r_winner;
                end else begin
                    w_cnt_nxt    = r_cnt + CNT_W'(1);
`endif
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                w_last_nxt  = r_winner;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_winner  <= 1'b0;
            r_last    <= 1'b1;
            r_a       <= '0;
            r_b       <= '0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            result    <= '0;
            busy      <= 1'b0;
            mul_a     <= '0;
            mul_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_winner  <= w_winner_nxt;
            r_last    <= w_last_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            done0     <= w_done0_nxt;
            done1     <= w_done1_nxt;
            result    <= w_result_nxt;
            busy      <= w_busy_nxt;
            mul_a     <= w_mul_a_nxt;
            mul_valid <= w_mul_valid_nxt;
        end
    end

`ifdef FPMUL_ARB_TIMEOUT_EN
    // WAIT cycle counter and timeout flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            err   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            err   <= w_err_nxt;
        end
    end
`endif

endmodule
